// File: rtl/pipe_mem_responder_if.sv
// CPU-to-memory bus bundle: one instruction fetch port and one
// stall/ack handshaked data port.
interface pipe_mem_responder_if;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        mem_req;
    logic        mem_rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;
    logic        err;
    logic        stall;

    modport master (
        output pc, mem_req, mem_rw, addr, wdata,
        input  inst, rdata, ack, err, stall
    );

    modport slave (
        input  pc, mem_req, mem_rw, addr, wdata,
        output inst, rdata, ack, err, stall
    );
endinterface

// File: rtl/pipe_mem_responder.sv
// Unified word-addressed RAM serving a single-cycle fetch port and a data
// port with LAT wait cycles and a stall/ack handshake.
module pipe_mem_responder #(
    parameter int ADDR_W = 10,
    parameter int LAT    = 2     // data wait cycles, legal 1..7
) (
    input logic                 clk,
    input logic                 rst,
    pipe_mem_responder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state, state_nxt;
    logic [2:0]        cnt, cnt_nxt;
    logic [31:0]       ram [0:(1<<ADDR_W)-1];
    logic [ADDR_W-1:0] idx_l;
    logic [31:0]       wdata_l;
    logic              rw_l;
    logic              err_l;
    logic              bad;
    logic              accept;
    logic              commit;
    logic              unused_pc;

    // Fetch wraps modulo RAM size; the dropped pc bits are intentionally unused.
    assign unused_pc = ^{bus.pc[31:ADDR_W+2], bus.pc[1:0]};

    assign bad    = (bus.addr[1:0] != 2'b00) || (bus.addr[31:ADDR_W+2] != '0);
    assign accept = (state == IDLE) && bus.mem_req;
    assign commit = (state == WAIT) && (cnt == 3'd0);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        bus.stall = 1'b0;
        case (state)
            IDLE: begin
                if (bus.mem_req) begin
                    bus.stall = 1'b1;
                    if (bad) begin
                        state_nxt = RESP;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = 3'(LAT - 1);
                    end
                end
            end
            WAIT: begin
                bus.stall = 1'b1;
                if (cnt != 3'd0) cnt_nxt   = cnt - 3'd1;
                else             state_nxt = RESP;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 3'd0;
            idx_l   <= '0;
            wdata_l <= '0;
            rw_l    <= 1'b0;
            err_l   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                idx_l   <= bus.addr[ADDR_W+1:2];
                wdata_l <= bus.wdata;
                rw_l    <= bus.mem_rw;
                err_l   <= bad;
            end
        end
    end

    // Reset forces state to IDLE, so an aborted store can never commit.
    always_ff @(posedge clk) begin
        if (commit && rw_l) ram[idx_l] <= wdata_l;
    end

    // Fetch reads the pre-write word on a colliding edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) bus.inst <= '0;
        else     bus.inst <= ram[bus.pc[ADDR_W+1:2]];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 bus.rdata <= '0;
        else if (commit && !rw_l) bus.rdata <= ram[idx_l];
    end

    assign bus.ack = (state == RESP);
    assign bus.err = (state == RESP) && err_l;
endmodule

// File: tb/tb_pipe_mem_responder.sv
// Directed bench for pipe_mem_responder with a response scoreboard; also
// sweeps the data latency using LAT=1 and LAT=7 instances.
module tb_pipe_mem_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    int   ack1_cnt = 0;
    int   ack7_cnt = 0;

    always #5 clk = ~clk;

    pipe_mem_responder_if bus ();
    pipe_mem_responder_if bus1 ();
    pipe_mem_responder_if bus7 ();

    pipe_mem_responder #(.ADDR_W(10), .LAT(2)) dut  (.clk(clk), .rst(rst), .bus(bus.slave));
    pipe_mem_responder #(.ADDR_W(10), .LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
    pipe_mem_responder #(.ADDR_W(10), .LAT(7)) dut7 (.clk(clk), .rst(rst), .bus(bus7.slave));

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        string       tag;
    } sb_t;

    sb_t         sbq [$];
    logic [31:0] model_mem [int];
    logic [31:0] model_rdata = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every ack on the main instance pops one expected response.
    always @(negedge clk) begin
        sb_t e;
        if (bus.ack === 1'b1) begin
            if (sbq.size() == 0) begin
                check("unexpected_ack", {31'd0, bus.ack}, 32'd0);
            end else begin
                e = sbq.pop_front();
                check({e.tag, "_err"}, {31'd0, bus.err}, {31'd0, e.err});
                check({e.tag, "_rdata"}, bus.rdata, e.rdata);
            end
        end
        if (bus1.ack === 1'b1) ack1_cnt++;
        if (bus7.ack === 1'b1) ack7_cnt++;
    end

    // Main-instance data access (LAT=2); returns inst as seen in the ack cycle.
    task automatic access(input logic rw, input logic [31:0] a, input logic [31:0] wd,
                          input string tag, output logic [31:0] inst_at_ack);
        logic bad;
        sb_t  e;
        int   nst;
        logic got;
        nst = 0;
        got = 1'b0;
        bad = (a[1:0] != 2'b00) || (a[31:12] != 20'd0);
        if (!bad) begin
            if (rw) model_mem[int'(a[11:2])] = wd;
            else    model_rdata = model_mem[int'(a[11:2])];
        end
        e.err = bad;
        e.rdata = model_rdata;
        e.tag = tag;
        sbq.push_back(e);
        @(posedge clk); #1;
        bus.mem_req = 1'b1;
        bus.mem_rw  = rw;
        bus.addr    = a;
        bus.wdata   = wd;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (bus.ack === 1'b1)        got = 1'b1;
            else if (bus.stall === 1'b1) nst++;
        end
        check({tag, "_ack_seen"}, {31'd0, got}, 32'd1);
        check({tag, "_stall_cycles"}, nst, bad ? 32'd1 : 32'd3);
        check({tag, "_stall_in_ack"}, {31'd0, bus.stall}, 32'd0);
        inst_at_ack = bus.inst;
        bus.mem_req = 1'b0;
    endtask

    // Latency sweep on the LAT=1 / LAT=7 instances; mem_req is held through WAIT.
    task automatic sweep(input int which, input int lat, input logic rw, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] exp_rd, input string tag);
        int   n;
        int   acks0;
        logic got;
        n = 0;
        got = 1'b0;
        acks0 = (which == 1) ? ack1_cnt : ack7_cnt;
        @(posedge clk); #1;
        if (which == 1) begin
            bus1.mem_req = 1'b1; bus1.mem_rw = rw; bus1.addr = a; bus1.wdata = wd;
        end else begin
            bus7.mem_req = 1'b1; bus7.mem_rw = rw; bus7.addr = a; bus7.wdata = wd;
        end
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            n++;
            got = (which == 1) ? (bus1.ack === 1'b1) : (bus7.ack === 1'b1);
        end
        bus1.mem_req = 1'b0;
        bus7.mem_req = 1'b0;
        check({tag, "_ack_seen"}, {31'd0, got}, 32'd1);
        check({tag, "_req_to_ack"}, n - 1, lat + 1);
        if (!rw) check({tag, "_rdata"}, (which == 1) ? bus1.rdata : bus7.rdata, exp_rd);
        repeat (lat + 4) @(negedge clk);
        check({tag, "_ack_count"}, ((which == 1) ? ack1_cnt : ack7_cnt) - acks0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] ia;
        bus.pc = '0;  bus.mem_req = 1'b0;  bus.mem_rw = 1'b0;  bus.addr = '0;  bus.wdata = '0;
        bus1.pc = '0; bus1.mem_req = 1'b0; bus1.mem_rw = 1'b0; bus1.addr = '0; bus1.wdata = '0;
        bus7.pc = '0; bus7.mem_req = 1'b0; bus7.mem_rw = 1'b0; bus7.addr = '0; bus7.wdata = '0;

        // Reset state
        @(negedge clk);
        check("rst_inst",  bus.inst, 32'd0);
        check("rst_rdata", bus.rdata, 32'd0);
        check("rst_ack",   {31'd0, bus.ack}, 32'd0);
        check("rst_err",   {31'd0, bus.err}, 32'd0);
        check("rst_stall", {31'd0, bus.stall}, 32'd0);
        rst = 1'b0;

        // Preload through the data port
        access(1'b1, 32'h0000_0000, 32'h0000_0013, "st_w0", ia);
        access(1'b1, 32'h0000_0004, 32'h0010_0093, "st_w1", ia);
        access(1'b1, 32'h0000_0010, 32'h1111_1111, "st_w4", ia);
        access(1'b1, 32'h0000_0080, 32'h0BAD_F00D, "st_w32", ia);

        // Reset then fetch; RAM survives reset
        bus.pc = 32'h0;
        @(negedge clk);
        rst = 1'b1;
        model_rdata = '0;
        @(negedge clk);
        check("rstpulse_inst", bus.inst, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        bus.pc = 32'h4;
        @(negedge clk);
        check("fetch_pc0", bus.inst, 32'h0000_0013);
        @(negedge clk);
        check("fetch_pc4", bus.inst, 32'h0010_0093);

        // Store then load
        access(1'b1, 32'h0000_0040, 32'hDEAD_BEEF, "st40", ia);
        access(1'b0, 32'h0000_0040, 32'h0, "ld40", ia);
        @(negedge clk);
        check("ld40_hold", bus.rdata, 32'hDEAD_BEEF);

        // Misaligned and out-of-range requests
        access(1'b0, 32'h0000_0042, 32'h0, "err_misalign", ia);
        access(1'b1, 32'h0000_1000, 32'h9999_9999, "err_range", ia);
        access(1'b0, 32'h0000_0000, 32'h0, "ld_w0", ia);
        check("w0_intact", bus.rdata, 32'h0000_0013);

        // Fetch/store collision on word 4
        bus.pc = 32'h10;
        access(1'b1, 32'h0000_0010, 32'h2222_2222, "coll", ia);
        check("coll_old_word", ia, 32'h1111_1111);
        @(negedge clk);
        check("coll_new_word", bus.inst, 32'h2222_2222);

        // Reset in the middle of a store's WAIT phase
        @(posedge clk); #1;
        bus.mem_req = 1'b1; bus.mem_rw = 1'b1; bus.addr = 32'h80; bus.wdata = 32'h55AA_55AA;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        bus.mem_req = 1'b0;
        model_rdata = '0;
        repeat (2) begin
            @(negedge clk);
            check("midrst_no_ack", {31'd0, bus.ack}, 32'd0);
        end
        rst = 1'b0;
        access(1'b0, 32'h0000_0080, 32'h0, "ld80_after_abort", ia);
        check("abort_kept_old", bus.rdata, 32'h0BAD_F00D);

        // Latency sweep
        sweep(1, 1, 1'b1, 32'h20, 32'hCAFE_F00D, 32'h0, "lat1_st");
        sweep(1, 1, 1'b0, 32'h20, 32'h0, 32'hCAFE_F00D, "lat1_ld");
        sweep(7, 7, 1'b1, 32'h24, 32'h1234_5678, 32'h0, "lat7_st");
        sweep(7, 7, 1'b0, 32'h24, 32'h0, 32'h1234_5678, "lat7_ld");

        repeat (3) @(negedge clk);
        check("sb_drained", sbq.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
